// File: rtl/adder_tree.sv
// Pipelined, back-pressurable unsigned adder tree reducing KERNEL_SIZE^2 products to one word.
// Optional feature: define ADDER_TREE_BIAS_EN to add a `bias` port summed in as the last leaf.
module adder_tree #(
   parameter int DATA_WIDTH  = 32,
   parameter int KERNEL_SIZE = 3
) (
   input  logic                                            clk,
   input  logic                                            reset,
   input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   products,
`ifdef ADDER_TREE_BIAS_EN
   input  logic [DATA_WIDTH-1:0]                           bias,
`endif
   input  logic                                            in_valid,
   output logic                                            in_ready,
   output logic [DATA_WIDTH-1:0]                           sum,
   output logic                                            out_valid,
   input  logic                                            out_ready
);

   localparam int N_TAPS = KERNEL_SIZE * KERNEL_SIZE;
`ifdef ADDER_TREE_BIAS_EN
   localparam int N_LEAVES = N_TAPS + 1;
`else
   localparam int N_LEAVES = N_TAPS;
`endif
   localparam int LATENCY = ($clog2(N_LEAVES) < 1) ? 1 : $clog2(N_LEAVES);

   // Number of elements held by level lvl after repeated pairwise halving.
   function automatic int level_count(input int lvl);
      int c;
      c = N_LEAVES;
      for (int k = 0; k <= lvl; k++) begin
         c = (c + 1) / 2;
      end
      return c;
   endfunction

   logic [DATA_WIDTH-1:0] leaves [N_LEAVES];
   logic                  adv;

   for (genvar j = 0; j < N_TAPS; j++) begin : g_leaf
      assign leaves[j] = products[j*DATA_WIDTH +: DATA_WIDTH];
   end
`ifdef ADDER_TREE_BIAS_EN
   assign leaves[N_TAPS] = bias;
`endif

   // Whole pipeline moves together; it only stalls when a finished sum is waiting.
   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;

   for (genvar l = 0; l < LATENCY; l++) begin : g_lvl
      localparam int PREV = (l == 0) ? N_LEAVES : level_count(l - 1);
      localparam int CNT  = level_count(l);

      logic [DATA_WIDTH-1:0] src [PREV];
      logic                  src_valid;
      logic [DATA_WIDTH-1:0] node_sum [CNT];
      logic [DATA_WIDTH-1:0] data_d [CNT];
      logic [DATA_WIDTH-1:0] data_q [CNT];
      logic                  valid_d;
      logic                  valid_q;

      if (l == 0) begin : g_src
         assign src       = leaves;
         assign src_valid = in_valid;
      end else begin : g_src
         assign src       = g_lvl[l-1].data_q;
         assign src_valid = g_lvl[l-1].valid_q;
      end

      for (genvar i = 0; i < CNT; i++) begin : g_node
         if (2*i + 1 < PREV) begin : g_pair
            assign node_sum[i] = src[2*i] + src[2*i+1];
         end else begin : g_pass
            assign node_sum[i] = src[2*i];
         end
      end

      always_comb begin
         valid_d = valid_q;
         for (int i = 0; i < CNT; i++) begin
            data_d[i] = data_q[i];
         end
         if (adv) begin
            valid_d = src_valid;
            for (int i = 0; i < CNT; i++) begin
               data_d[i] = node_sum[i];
            end
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int i = 0; i < CNT; i++) begin
               data_q[i] <= '0;
            end
            valid_q <= 1'b0;
         end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
         end
      end
   end

   assign sum       = g_lvl[LATENCY-1].data_q[0];
   assign out_valid = g_lvl[LATENCY-1].valid_q;

endmodule

// File: tb/tb_adder_tree.sv
// Directed self-checking bench for adder_tree (KERNEL_SIZE=3, DATA_WIDTH=32, latency 4).
// Honours ADDER_TREE_BIAS_EN when the design is built with it.
module tb_adder_tree;

   localparam int DW = 32;
   localparam int K  = 3;
   localparam int NT = K * K;
`ifdef ADDER_TREE_BIAS_EN
   localparam bit HAS_BIAS = 1'b1;
`else
   localparam bit HAS_BIAS = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [NT*DW-1:0]  products;
   logic [DW-1:0]     bias;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     sum;
   logic              out_valid;
   logic              out_ready;

   int                vectors    = 0;
   int                miscompares = 0;
   logic [DW-1:0]     exp_q [$];

   always #5 clk = ~clk;

   adder_tree #(.DATA_WIDTH(DW), .KERNEL_SIZE(K)) dut (
      .clk       (clk),
      .reset     (reset),
      .products  (products),
`ifdef ADDER_TREE_BIAS_EN
      .bias      (bias),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum       (sum),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // Deterministic but irregular tap values; large enough that sums wrap.
   function automatic logic [NT*DW-1:0] make_vec(input int seed);
      logic [NT*DW-1:0] v;
      logic [DW-1:0]    s;
      logic [DW-1:0]    jj;
      s = DW'(seed);
      for (int j = 0; j < NT; j++) begin
         jj = DW'(j);
         v[j*DW +: DW] = s * 32'h9E3779B9 + jj * 32'h7F4A7C15 + 32'h0BADF00D;
      end
      return v;
   endfunction

   function automatic logic [NT*DW-1:0] fill_vec(input logic [DW-1:0] tap);
      logic [NT*DW-1:0] v;
      for (int j = 0; j < NT; j++) v[j*DW +: DW] = tap;
      return v;
   endfunction

   function automatic logic [DW-1:0] ref_sum(input logic [NT*DW-1:0] p, input logic [DW-1:0] b);
      logic [DW-1:0] acc;
      acc = HAS_BIAS ? b : '0;
      for (int j = 0; j < NT; j++) acc = acc + p[j*DW +: DW];
      return acc;
   endfunction

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; products = '0; bias = '0;
      repeat (2) @(negedge clk);
      vectors++; if (sum !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_sum: got %0h expected 0", sum); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
      reset = 1'b0;
      @(negedge clk);
      products = fill_vec(32'h1); in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; products = '0;
      for (int k = 0; k < 6; k++) begin
         vectors++;
         if (out_valid !== (k == 3)) begin
            miscompares++; $display("[TB] FAIL ones_valid[%0d]: got %0b expected %0b", k, out_valid, (k == 3));
         end
         if (k == 3) begin
            vectors++;
            if (sum !== 32'd9) begin miscompares++; $display("[TB] FAIL ones_sum: got %0h expected 9", sum); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_wrap();
      out_ready = 1'b1;
      products = fill_vec(32'hFFFF_FFFF); in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; products = '0;
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (out_valid !== (k == 3)) begin
            miscompares++; $display("[TB] FAIL wrap_valid[%0d]: got %0b expected %0b", k, out_valid, (k == 3));
         end
         if (k == 3) begin
            vectors++;
            if (sum !== 32'hFFFF_FFF7) begin miscompares++; $display("[TB] FAIL wrap_sum: got %0h expected fffffff7", sum); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_streaming();
      int sent = 0, got = 0, gaps = 0;
      bit started = 1'b0;
      exp_q.delete();
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && got < 20; cyc++) begin
         if (sent < 20) begin products = make_vec(100 + sent); in_valid = 1'b1; end
         else begin in_valid = 1'b0; products = '0; end
         #1;
         if (out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++; $display("[TB] FAIL stream_extra: got %0h expected no output", sum);
            end else if (sum !== exp_q[0]) begin
               miscompares++; $display("[TB] FAIL stream_sum[%0d]: got %0h expected %0h", got, sum, exp_q[0]);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            got++; started = 1'b1;
         end else if (started && got < 20) begin
            gaps++;
         end
         if (in_valid && in_ready) begin exp_q.push_back(ref_sum(products, bias)); sent++; end
         @(negedge clk);
      end
      in_valid = 1'b0;
      vectors++; if (got != 20) begin miscompares++; $display("[TB] FAIL stream_count: got %0d expected 20", got); end
      vectors++; if (gaps != 0) begin miscompares++; $display("[TB] FAIL stream_gaps: got %0d expected 0", gaps); end
   endtask

   task automatic test_fill_while_blocked();
      logic [DW-1:0] expv;
      out_ready = 1'b0;
      products = make_vec(7); in_valid = 1'b1;
      expv = ref_sum(products, bias);
      @(negedge clk);
      in_valid = 1'b0; products = '0;
      for (int k = 0; k < 6; k++) begin
         vectors++;
         if (out_valid !== (k >= 3) || in_ready !== (k < 3)) begin
            miscompares++;
            $display("[TB] FAIL blocked_fill[%0d]: got valid=%0b ready=%0b expected valid=%0b ready=%0b",
                     k, out_valid, in_ready, (k >= 3), (k < 3));
         end
         if (k >= 3) begin
            vectors++;
            if (sum !== expv) begin miscompares++; $display("[TB] FAIL blocked_sum[%0d]: got %0h expected %0h", k, sum, expv); end
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL blocked_drain: got %0b expected 0", out_valid); end
   endtask

   task automatic test_back_pressure();
      int sent = 0, got = 0;
      exp_q.delete();
      for (int cyc = 0; cyc < 60 && got < 12; cyc++) begin
         out_ready = !(cyc >= 8 && cyc < 13);
         if (sent < 12) begin products = make_vec(300 + sent); in_valid = 1'b1; end
         else begin in_valid = 1'b0; products = '0; end
         #1;
         if (!out_ready) begin
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || exp_q.size() == 0 || sum !== exp_q[0]) begin
               miscompares++;
               $display("[TB] FAIL stall[%0d]: got ready=%0b valid=%0b sum=%0h expected ready=0 valid=1 sum=%0h",
                        cyc, in_ready, out_valid, sum, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
            end
         end
         if (out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++; $display("[TB] FAIL bp_extra: got %0h expected no output", sum);
            end else if (sum !== exp_q[0]) begin
               miscompares++; $display("[TB] FAIL bp_sum[%0d]: got %0h expected %0h", got, sum, exp_q[0]);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            got++;
         end
         if (in_valid && in_ready) begin exp_q.push_back(ref_sum(products, bias)); sent++; end
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      vectors++; if (got != 12) begin miscompares++; $display("[TB] FAIL bp_count: got %0d expected 12", got); end
      repeat (5) @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_duplicate: got valid=%0b expected 0", out_valid); end
   endtask

   task automatic test_reset_mid_stream();
      logic [DW-1:0] expv;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         products = make_vec(500 + i); in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0; products = '0;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || sum !== 32'h0 || in_ready !== 1'b1) begin
         miscompares++; $display("[TB] FAIL midreset_clear: got valid=%0b sum=%0h ready=%0b expected 0/0/1", out_valid, sum, in_ready);
      end
      #2 reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         vectors++;
         if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_ghost[%0d]: got %0b expected 0", k, out_valid); end
      end
      products = make_vec(600); in_valid = 1'b1;
      expv = ref_sum(products, bias);
      @(negedge clk);
      in_valid = 1'b0; products = '0;
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (out_valid !== (k == 3) || (k == 3 && sum !== expv)) begin
            miscompares++; $display("[TB] FAIL post_reset[%0d]: got valid=%0b sum=%0h expected valid=%0b sum=%0h",
                                    k, out_valid, sum, (k == 3), expv);
         end
         @(negedge clk);
      end
   endtask

`ifdef ADDER_TREE_BIAS_EN
   task automatic test_bias();
      out_ready = 1'b1;
      for (int j = 0; j < NT; j++) products[j*DW +: DW] = DW'(j + 1);
      bias = 32'd100; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; products = '0; bias = '0;
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (out_valid !== (k == 3) || (k == 3 && sum !== 32'd145)) begin
            miscompares++; $display("[TB] FAIL bias[%0d]: got valid=%0b sum=%0d expected valid=%0b sum=145",
                                    k, out_valid, sum, (k == 3));
         end
         @(negedge clk);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_wrap();
      test_streaming();
      test_fill_while_blocked();
      test_back_pressure();
      test_reset_mid_stream();
`ifdef ADDER_TREE_BIAS_EN
      test_bias();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
